// File: rtl/bn_seq_pkg.sv
// +----------------------------------------------------------------------+
// | bn_seq_pkg: shared types for the layer-7 BN/residual sequencer        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package bn_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CALC  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Datapath mode encoding is fixed by the existing datapath.
  localparam logic MODE_RELOAD = 1'b0;
  localparam logic MODE_CALC   = 1'b1;

endpackage

`default_nettype wire

// File: rtl/bn_para_fetch.sv
// +----------------------------------------------------------------------+
// | bn_para_fetch: one-outstanding parameter fetch and reg-file writer    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module bn_para_fetch #(
  parameter int CHANNEL_NUM = 512,
  parameter int PARA_WIDTH  = 16,
  parameter int CH_AW       = $clog2(CHANNEL_NUM)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic                  para_vld_i,
  input  logic [PARA_WIDTH-1:0] para_a_i,
  input  logic [PARA_WIDTH-1:0] para_b_i,
  output logic                  para_req_o,
  output logic [CH_AW-1:0]      para_addr_o,
  output logic                  bn_we_o,
  output logic [CH_AW-1:0]      bn_waddr_o,
  output logic [PARA_WIDTH-1:0] bn_wa_o,
  output logic [PARA_WIDTH-1:0] bn_wb_o,
  output logic                  last_we_o
);

  localparam logic [CH_AW-1:0] LAST_ADDR = CH_AW'(CHANNEL_NUM - 1);

  logic                  req_q, req_d;
  logic [CH_AW-1:0]      addr_q, addr_d;
  logic                  we_q, we_d;
  logic [CH_AW-1:0]      waddr_q, waddr_d;
  logic [PARA_WIDTH-1:0] wa_q, wa_d;
  logic [PARA_WIDTH-1:0] wb_q, wb_d;

  always_comb begin
    req_d   = req_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wa_d    = wa_q;
    wb_d    = wb_q;
    if (load_i) begin
      req_d  = 1'b1;
      addr_d = '0;
    end else if (req_q && para_vld_i) begin
      req_d   = 1'b0;
      we_d    = 1'b1;
      waddr_d = addr_q;
      wa_d    = para_a_i;
      wb_d    = para_b_i;
    end else if (we_q && (waddr_q != LAST_ADDR)) begin
      // Request gap is exactly the write cycle; next channel follows.
      req_d  = 1'b1;
      addr_d = addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q   <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wa_q    <= '0;
      wb_q    <= '0;
    end else begin
      req_q   <= req_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wa_q    <= wa_d;
      wb_q    <= wb_d;
    end
  end

  assign para_req_o  = req_q;
  assign para_addr_o = addr_q;
  assign bn_we_o     = we_q;
  assign bn_waddr_o  = waddr_q;
  assign bn_wa_o     = wa_q;
  assign bn_wb_o     = wb_q;
  assign last_we_o   = we_q && (waddr_q == LAST_ADDR);

endmodule

`default_nettype wire

// File: rtl/bn_res_seq_layer7.sv
// +----------------------------------------------------------------------+
// | bn_res_seq_layer7: sequencer for the layer-7 BN + residual datapath   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module bn_res_seq_layer7
  import bn_seq_pkg::*;
#(
  parameter int CHANNEL_NUM = 512,
  parameter int PIXEL_NUM   = 16,
  parameter int PARA_WIDTH  = 16,
  parameter int CH_AW       = $clog2(CHANNEL_NUM),
  parameter int PIX_AW      = $clog2(PIXEL_NUM)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  start_noload,
  output logic                  para_req,
  output logic [CH_AW-1:0]      para_addr,
  input  logic                  para_vld,
  input  logic [PARA_WIDTH-1:0] para_a,
  input  logic [PARA_WIDTH-1:0] para_b,
  output logic                  bn_we,
  output logic [CH_AW-1:0]      bn_waddr,
  output logic [PARA_WIDTH-1:0] bn_wa,
  output logic [PARA_WIDTH-1:0] bn_wb,
  output logic                  mode,
  input  logic                  psum_e,
  output logic                  res_re,
  output logic [PIX_AW-1:0]     res_raddr,
  output logic                  bn_data_e,
  input  logic                  bn_e_out,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);

  localparam int               CNT_W   = PIX_AW + 1;
  localparam logic [CNT_W-1:0] PIX_END = CNT_W'(PIXEL_NUM);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             overrun_q, overrun_d;
  logic             data_e_q;
  logic             load_go;
  logic             accept;
  logic             last_we;
  logic             in_pass;

  assign load_go = (state_q == ST_IDLE) && start;
  assign in_pass = (state_q == ST_CALC) || (state_q == ST_DRAIN);
  assign accept  = (state_q == ST_CALC) && psum_e && (in_cnt_q < PIX_END);

  bn_para_fetch #(
    .CHANNEL_NUM (CHANNEL_NUM),
    .PARA_WIDTH  (PARA_WIDTH),
    .CH_AW       (CH_AW)
  ) u_fetch (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load_go),
    .para_vld_i  (para_vld),
    .para_a_i    (para_a),
    .para_b_i    (para_b),
    .para_req_o  (para_req),
    .para_addr_o (para_addr),
    .bn_we_o     (bn_we),
    .bn_waddr_o  (bn_waddr),
    .bn_wa_o     (bn_wa),
    .bn_wb_o     (bn_wb),
    .last_we_o   (last_we)
  );

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    overrun_d = overrun_q;
    if (accept) in_cnt_d = in_cnt_q + 1'b1;
    if (in_pass && bn_e_out && (out_cnt_q < PIX_END)) out_cnt_d = out_cnt_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_LOAD;
          overrun_d = 1'b0;
        end else if (start_noload) begin
          state_d   = ST_CALC;
          overrun_d = 1'b0;
          in_cnt_d  = '0;
          out_cnt_d = '0;
        end
      end
      ST_LOAD: begin
        if (last_we) begin
          state_d   = ST_CALC;
          in_cnt_d  = '0;
          out_cnt_d = '0;
        end
      end
      ST_CALC: begin
        if (accept && (in_cnt_q == PIX_END - 1'b1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (psum_e) overrun_d = 1'b1;
        if (out_cnt_q == PIX_END) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      overrun_q <= 1'b0;
      data_e_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      overrun_q <= overrun_d;
      data_e_q  <= accept;
    end
  end

  // Residual read data lands one cycle after res_re, so data_e trails it.
  assign res_re    = accept;
  assign res_raddr = in_cnt_q[PIX_AW-1:0];
  assign bn_data_e = data_e_q;
  assign mode      = in_pass ? MODE_CALC : MODE_RELOAD;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DRAIN) && (out_cnt_q == PIX_END);
  assign overrun   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_bn_res_seq_layer7.sv
// +----------------------------------------------------------------------+
// | tb_bn_res_seq_layer7: scoreboard bench for the layer-7 sequencer      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_bn_res_seq_layer7;

  localparam int CH     = 4;
  localparam int PIX    = 3;
  localparam int PW     = 16;
  localparam int CH_AW  = 2;
  localparam int PIX_AW = 2;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, start_noload = 1'b0;
  logic para_vld = 1'b0, psum_e = 1'b0, bn_e_out = 1'b0;
  logic [PW-1:0] para_a = '0, para_b = '0;
  logic para_req, bn_we, mode, res_re, bn_data_e, busy, done, overrun;
  logic [CH_AW-1:0] para_addr, bn_waddr;
  logic [PW-1:0] bn_wa, bn_wb;
  logic [PIX_AW-1:0] res_raddr;

  typedef struct {int cyc; int d0; int d1; int d2;} ev_t;
  ev_t q_we[$];
  ev_t q_res[$];
  ev_t q_dat[$];
  ev_t q_done[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int k = 0;
  int age = 0;
  logic resp_en = 1'b0;
  logic lb = 1'b0;

  bn_res_seq_layer7 #(
    .CHANNEL_NUM (CH),
    .PIXEL_NUM   (PIX),
    .PARA_WIDTH  (PW),
    .CH_AW       (CH_AW),
    .PIX_AW      (PIX_AW)
  ) dut (
    .clk (clk), .rst_n (rst_n), .start (start), .start_noload (start_noload),
    .para_req (para_req), .para_addr (para_addr), .para_vld (para_vld),
    .para_a (para_a), .para_b (para_b), .bn_we (bn_we), .bn_waddr (bn_waddr),
    .bn_wa (bn_wa), .bn_wb (bn_wb), .mode (mode), .psum_e (psum_e),
    .res_re (res_re), .res_raddr (res_raddr), .bn_data_e (bn_data_e),
    .bn_e_out (bn_e_out), .busy (busy), .done (done), .overrun (overrun)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Parameter memory: answers each request two cycles after it appears.
  initial forever begin
    tick();
    para_vld = 1'b0;
    if (para_req) begin
      if (!resp_en) chk("req_unexpected", 1, 0);
      else begin
        age++;
        if (age == 3) begin
          chk("req_addr", para_addr, k);
          para_vld = 1'b1;
          para_a   = PW'(k + 10);
          para_b   = PW'(k + 20);
          q_we.push_back('{cyc + 1, k, k + 10, k + 20});
          k++;
          age = 0;
        end
      end
    end else age = 0;
  end

  // Datapath stand-in: data_e_out one cycle after data_e.
  initial forever begin
    @(negedge clk);
    lb = bn_data_e;
    tick();
    bn_e_out = lb;
  end

  // Monitor: pops an expectation whenever the DUT presents an event.
  initial forever begin
    ev_t e;
    @(negedge clk);
    if (bn_we) begin
      if (q_we.size() == 0) chk("we_unexpected", 1, 0);
      else begin
        e = q_we.pop_front();
        chk("we_cycle", cyc, e.cyc);
        chk("we_addr", bn_waddr, e.d0);
        chk("we_a", bn_wa, e.d1);
        chk("we_b", bn_wb, e.d2);
        chk("we_mode", mode, 0);
      end
    end
    if (res_re) begin
      if (q_res.size() == 0) chk("res_unexpected", 1, 0);
      else begin
        e = q_res.pop_front();
        chk("res_cycle", cyc, e.cyc);
        chk("res_addr", res_raddr, e.d0);
      end
    end
    if (bn_data_e) begin
      if (q_dat.size() == 0) chk("data_e_unexpected", 1, 0);
      else begin
        e = q_dat.pop_front();
        chk("data_e_cycle", cyc, e.cyc);
      end
    end
    if (done) begin
      if (q_done.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        e = q_done.pop_front();
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic psum(input int pix, input bit last);
    psum_e = 1'b1;
    q_res.push_back('{cyc, pix, 0, 0});
    q_dat.push_back('{cyc + 1, 0, 0, 0});
    if (last) q_done.push_back('{cyc + 3, 0, 0, 0});
    tick();
    psum_e = 1'b0;
  endtask

  task automatic wait_last_write();
    int i;
    for (i = 0; i < 100 && !(bn_we && bn_waddr == CH_AW'(CH - 1)); i++) tick();
    chk("last_write_seen", int'(bn_we), 1);
    chk("mode_at_last_write", mode, 0);
    tick();
    chk("mode_after_load", mode, 1);
    chk("req_after_load", para_req, 0);
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 50 && !done; i++) tick();
    chk("done_seen", int'(done), 1);
    tick();
    chk("busy_after_done", busy, 0);
    chk("mode_after_done", mode, 0);
  endtask

  task automatic check_all_zero(input string nm);
    chk(nm, int'({para_req, para_addr, bn_we, bn_waddr, bn_wa, bn_wb, mode,
                  res_re, res_raddr, bn_data_e, busy, done, overrun}), 0);
  endtask

  initial begin
    int i;
    tick();
    tick();
    check_all_zero("reset_outputs");
    rst_n = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // Full load then a back-to-back pass.
    k = 0; resp_en = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    chk("load_busy", busy, 1);
    chk("load_req", para_req, 1);
    chk("load_addr0", para_addr, 0);
    wait_last_write();
    resp_en = 1'b0;
    psum(0, 1'b0); psum(1, 1'b0); psum(2, 1'b1);
    wait_done();
    chk("no_overrun", overrun, 0);

    // Reuse parameters, gapped psum_e.
    start_noload = 1'b1; tick(); start_noload = 1'b0;
    chk("noload_mode", mode, 1);
    chk("noload_req", para_req, 0);
    psum(0, 1'b0); tick(); tick(); tick();
    psum(1, 1'b0); psum(2, 1'b1);
    wait_done();

    // Extra psum_e in DRAIN raises sticky overrun.
    start_noload = 1'b1; tick(); start_noload = 1'b0;
    psum(0, 1'b0); psum(1, 1'b0); psum(2, 1'b1);
    psum_e = 1'b1; tick(); psum_e = 1'b0;
    chk("overrun_set", overrun, 1);
    wait_done();
    chk("overrun_sticky", overrun, 1);

    // Start clears overrun; reset mid-load at addr 2.
    k = 0; resp_en = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    chk("overrun_cleared", overrun, 0);
    for (i = 0; i < 100 && !(para_req && para_addr == 2'd2); i++) tick();
    chk("addr2_seen", int'(para_req), 1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check_all_zero("abort_outputs");

    // Reload from zero; a start during CALC is ignored.
    k = 0;
    start = 1'b1; tick(); start = 1'b0;
    chk("reload_addr0", para_addr, 0);
    wait_last_write();
    resp_en = 1'b0;
    psum(0, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    psum(1, 1'b0); psum(2, 1'b1);
    wait_done();

    for (i = 0; i < 6; i++) tick();
    chk("we_left", q_we.size(), 0);
    chk("res_left", q_res.size(), 0);
    chk("data_e_left", q_dat.size(), 0);
    chk("done_left", q_done.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
